blob_labeler: RTL and testbench

//  Streaming connected-component counter for a binary raster pixel stream (1 bit/pixel, row-major).

---
 rtl/blob_labeler.sv | 199 +++++++++++++++++++
 tb/tb_blob_labeler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_labeler.sv
// blob_labeler: streaming single-pass connected-component counter for a 1-bit row-major raster.
// Define BLOB_CONN8_EN for 8-connectivity; the default build uses 4-connectivity.
module blob_labeler #(
   parameter  int unsigned IMG_W      = 640,
   parameter  int unsigned IMG_H      = 480,
   parameter  int unsigned MAX_LABELS = 256,
   parameter  int unsigned MIN_AREA   = 1,
   localparam int unsigned LBL_W      = $clog2(MAX_LABELS),
   localparam int unsigned AREA_W     = $clog2(IMG_W * IMG_H + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic             i_seq,
   output logic             o_ready,
   output logic             o_valid,
   output logic [LBL_W-1:0] o_count,
   output logic             o_overflow
);

   localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned NL_W  = LBL_W + 1;

   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [NL_W-1:0]   NL_MAX   = NL_W'(MAX_LABELS);
   localparam logic [LBL_W-1:0]  LBL_TOP  = LBL_W'(MAX_LABELS - 1);
   localparam logic [AREA_W-1:0] AREA_MAX = '1;
   localparam logic [AREA_W-1:0] AREA_MIN = AREA_W'(MIN_AREA);

   typedef enum logic [2:0] {StClear, StScan, StResolve, StAccum, StCount, StDone} state_e;

   state_e            state_q;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic [NL_W-1:0]   next_label_q;
   logic [LBL_W-1:0]  idx_q;
   logic [LBL_W-1:0]  cnt_q;
   logic              ovf_int_q;
   logic [LBL_W-1:0]  lbl_l_q;
   logic [LBL_W-1:0]  rowbuf_q [IMG_W];
   logic [LBL_W-1:0]  parent_q [MAX_LABELS];
   logic [AREA_W-1:0] area_q   [MAX_LABELS];

   logic [LBL_W-1:0]      lbl_l, lbl_u, r_l, r_u, min_root, cur_label, cnt_next;
   logic                  any_nb, idx_live, idx_last, accept;
   logic [MAX_LABELS-1:0] merge_hit;
   logic [NL_W-1:0]       idx_ext;
   logic [AREA_W:0]       acc_sum;
`ifdef BLOB_CONN8_EN
   logic [LBL_W-1:0]      lbl_ul_q, lbl_ul, lbl_ur, r_ul, r_ur;
`endif

   assign o_ready = (state_q == StScan);
   assign accept  = i_valid && (state_q == StScan);

   always_comb begin
      lbl_l    = (col_q == '0) ? '0 : lbl_l_q;
      lbl_u    = (row_q == '0) ? '0 : rowbuf_q[col_q];
      r_l      = parent_q[lbl_l];
      r_u      = parent_q[lbl_u];
      any_nb   = (lbl_l != '0) || (lbl_u != '0);
      // All-ones never undercuts a real root, so it stands in for an absent neighbour
      min_root = '1;
      if ((lbl_l != '0) && (r_l < min_root)) min_root = r_l;
      if ((lbl_u != '0) && (r_u < min_root)) min_root = r_u;
      for (int i = 0; i < MAX_LABELS; i++) begin
         merge_hit[i] = ((lbl_l != '0) && (parent_q[i] == r_l)) ||
                        ((lbl_u != '0) && (parent_q[i] == r_u));
      end
`ifdef BLOB_CONN8_EN
      lbl_ul = ((row_q == '0) || (col_q == '0)) ? '0 : lbl_ul_q;
      lbl_ur = ((row_q == '0) || (col_q == COL_LAST)) ? '0 : rowbuf_q[col_q + 1'b1];
      r_ul   = parent_q[lbl_ul];
      r_ur   = parent_q[lbl_ur];
      any_nb = any_nb || (lbl_ul != '0) || (lbl_ur != '0);
      if ((lbl_ul != '0) && (r_ul < min_root)) min_root = r_ul;
      if ((lbl_ur != '0) && (r_ur < min_root)) min_root = r_ur;
      for (int i = 0; i < MAX_LABELS; i++) begin
         merge_hit[i] = merge_hit[i] || ((lbl_ul != '0) && (parent_q[i] == r_ul)) ||
                        ((lbl_ur != '0) && (parent_q[i] == r_ur));
      end
`endif
      if (!i_seq) begin
         cur_label = '0;
      end else if (!any_nb) begin
         cur_label = (next_label_q == NL_MAX) ? LBL_TOP : next_label_q[LBL_W-1:0];
      end else begin
         cur_label = min_root;
      end

      idx_ext  = {1'b0, idx_q};
      idx_live = idx_ext < next_label_q;
      idx_last = (idx_ext + 1'b1) >= next_label_q;
      acc_sum  = {1'b0, area_q[parent_q[idx_q]]} + {1'b0, area_q[idx_q]};
      cnt_next = cnt_q;
      if (idx_live && (parent_q[idx_q] == idx_q) && (area_q[idx_q] >= AREA_MIN) &&
          (cnt_q != LBL_TOP)) begin
         cnt_next = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= StClear;
         col_q        <= '0;
         row_q        <= '0;
         next_label_q <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         ovf_int_q    <= 1'b0;
         lbl_l_q      <= '0;
         o_valid      <= 1'b0;
         o_count      <= '0;
         o_overflow   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         unique case (state_q)
            StClear: begin
               parent_q[idx_q] <= idx_q;
               area_q[idx_q]   <= '0;
               if (idx_q == LBL_TOP) begin
                  state_q      <= StScan;
                  next_label_q <= NL_W'(1);
                  idx_q        <= '0;
                  col_q        <= '0;
                  row_q        <= '0;
                  ovf_int_q    <= 1'b0;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            StScan: begin
               if (accept) begin
                  rowbuf_q[col_q] <= cur_label;
                  lbl_l_q         <= cur_label;
`ifdef BLOB_CONN8_EN
                  lbl_ul_q        <= lbl_u;
`endif
                  if (i_seq && !any_nb) begin
                     area_q[cur_label] <= AREA_W'(1);
                     if (next_label_q == NL_MAX) ovf_int_q <= 1'b1;
                     else next_label_q <= next_label_q + 1'b1;
                  end else if (i_seq) begin
                     if (area_q[min_root] != AREA_MAX) area_q[min_root] <= area_q[min_root] + 1'b1;
                     // Repoint every entry of a merged root so parent[] always names a true root
                     for (int i = 0; i < MAX_LABELS; i++) begin
                        if (merge_hit[i]) parent_q[i] <= min_root;
                     end
                  end
                  if (col_q == COL_LAST) begin
                     col_q <= '0;
                     row_q <= row_q + 1'b1;
                     if (row_q == ROW_LAST) begin
                        row_q   <= '0;
                        idx_q   <= LBL_W'(1);
                        state_q <= StResolve;
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            StResolve: begin
               if (idx_live) parent_q[idx_q] <= parent_q[parent_q[idx_q]];
               idx_q <= idx_last ? LBL_W'(1) : idx_q + 1'b1;
               if (idx_last) state_q <= StAccum;
            end
            StAccum: begin
               if (idx_live && (parent_q[idx_q] != idx_q)) begin
                  area_q[parent_q[idx_q]] <= acc_sum[AREA_W] ? AREA_MAX : acc_sum[AREA_W-1:0];
               end
               idx_q <= idx_last ? LBL_W'(1) : idx_q + 1'b1;
               if (idx_last) begin
                  cnt_q   <= '0;
                  state_q <= StCount;
               end
            end
            StCount: begin
               cnt_q <= cnt_next;
               idx_q <= idx_q + 1'b1;
               if (idx_last) begin
                  o_count    <= cnt_next;
                  o_overflow <= ovf_int_q;
                  o_valid    <= 1'b1;
                  state_q    <= StDone;
               end
            end
            StDone: begin
               idx_q   <= '0;
               state_q <= StClear;
            end
            default: state_q <= StClear;
         endcase
      end
   end

endmodule

// File: tb/tb_blob_labeler.sv
// Scoreboard bench for blob_labeler: two instances (MAX_LABELS 16/MIN_AREA 1 and 8/3) share one
// pixel stream; a flood-fill reference model predicts each frame's count and overflow flag.
module tb_blob_labeler;

   localparam int W = 8;
   localparam int H = 4;
   localparam int MAX_A = 16;
   localparam int MIN_A = 1;
   localparam int MAX_B = 8;
   localparam int MIN_B = 3;
`ifdef BLOB_CONN8_EN
   localparam bit CONN8 = 1'b1;
`else
   localparam bit CONN8 = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n, valid, seq;
   logic a_ready, a_valid, a_ovf, b_ready, b_valid, b_ovf;
   logic [$clog2(MAX_A)-1:0] a_count;
   logic [$clog2(MAX_B)-1:0] b_count;

   always #5 clk = ~clk;

   blob_labeler #(.IMG_W(W), .IMG_H(H), .MAX_LABELS(MAX_A), .MIN_AREA(MIN_A)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_seq(seq),
      .o_ready(a_ready), .o_valid(a_valid), .o_count(a_count), .o_overflow(a_ovf)
   );
   blob_labeler #(.IMG_W(W), .IMG_H(H), .MAX_LABELS(MAX_B), .MIN_AREA(MIN_B)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_seq(seq),
      .o_ready(b_ready), .o_valid(b_valid), .o_count(b_count), .o_overflow(b_ovf)
   );

   int total = 0;
   int bad = 0;
   bit pix [H][W];
   int q_cnt_a [$];
   int q_ovf_a [$];
   int q_cnt_b [$];
   int q_ovf_b [$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_le(input string name, input int act, input int lim);
      total++;
      if (act > lim) begin
         bad++;
         $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
      end
   endtask

   // Reference: true connected components by iterative min-label propagation
   function automatic void model(input int max_l, input int min_a, output int cnt, output bit ovf);
      int lab [H][W];
      int sz [H*W+1];
      bit chg;
      int newl;
      bit nb;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) lab[r][c] = pix[r][c] ? r * W + c + 1 : 0;
      do begin
         chg = 1'b0;
         for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
               if (lab[r][c] != 0) begin
                  for (int dr = -1; dr <= 1; dr++) begin
                     for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && (CONN8 || dr == 0 || dc == 0) &&
                            rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                           if (lab[rr][cc] != 0 && lab[rr][cc] < lab[r][c]) begin
                              lab[r][c] = lab[rr][cc];
                              chg = 1'b1;
                           end
                        end
                     end
                  end
               end
            end
         end
      end while (chg);
      for (int i = 0; i <= H * W; i++) sz[i] = 0;
      newl = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (pix[r][c]) begin
               sz[lab[r][c]]++;
               nb = 1'b0;
               if (c > 0 && pix[r][c-1]) nb = 1'b1;
               if (r > 0 && pix[r-1][c]) nb = 1'b1;
               if (CONN8 && r > 0 && c > 0 && pix[r-1][c-1]) nb = 1'b1;
               if (CONN8 && r > 0 && c < W - 1 && pix[r-1][c+1]) nb = 1'b1;
               if (!nb) newl++;
            end
         end
      end
      cnt = 0;
      for (int i = 1; i <= H * W; i++) if (sz[i] >= min_a) cnt++;
      if (cnt > max_l - 1) cnt = max_l - 1;
      ovf = (newl > max_l - 1);
   endfunction

   task automatic clear_frame();
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_a_ready"}, int'(a_ready), 0);
      chk({tag, "_a_valid"}, int'(a_valid), 0);
      chk({tag, "_a_count"}, int'(a_count), 0);
      chk({tag, "_a_ovf"}, int'(a_ovf), 0);
      chk({tag, "_b_ready"}, int'(b_ready), 0);
      chk({tag, "_b_valid"}, int'(b_valid), 0);
      chk({tag, "_b_count"}, int'(b_count), 0);
      chk({tag, "_b_ovf"}, int'(b_ovf), 0);
   endtask

   // Waits for both DUTs to be in SCAN, then streams the frame; abort resets mid-frame
   task automatic run_frame(input bit abort);
      int n;
      int ec;
      bit eo;
      n = 0;
      forever begin
         @(negedge clk);
         if (a_ready && b_ready) break;
         // Garbage pixels while neither DUT is ready must be ignored
         if (!a_ready && !b_ready) begin
            valid = 1'b1;
            seq = 1'(($urandom));
         end else begin
            valid = 1'b0;
         end
         n++;
         if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready a=%0d b=%0d expected 1 1", a_ready, b_ready);
            valid = 1'b0;
            return;
         end
      end
      if (!abort) begin
         model(MAX_A, MIN_A, ec, eo);
         q_cnt_a.push_back(ec);
         q_ovf_a.push_back(int'(eo));
         model(MAX_B, MIN_B, ec, eo);
         q_cnt_b.push_back(ec);
         q_ovf_b.push_back(int'(eo));
      end
      for (int k = 0; k < H * W; k++) begin
         if (k > 0) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
               valid = 1'b0;
               seq = 1'(($urandom));
               @(negedge clk);
            end
         end
         if (abort && k == 13) begin
            valid = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            check_reset_state("midreset");
            rst_n = 1'b1;
            return;
         end
         valid = 1'b1;
         seq = pix[k / W][k % W];
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   int held_a, rl_a, ec_a, eo_a;
   bit trk_a;
   always @(negedge clk) begin
      if (!rst_n) begin
         trk_a = 1'b0;
         held_a = 0;
      end else if (a_valid) begin
         if (q_cnt_a.size() == 0) begin
            total++;
            bad++;
            $display("FAIL a_unexpected_valid: got o_valid=1 expected no pending frame");
         end else begin
            ec_a = q_cnt_a.pop_front();
            eo_a = q_ovf_a.pop_front();
            chk("a_overflow", int'(a_ovf), eo_a);
            if (eo_a != 0) chk_le("a_count_bound", int'(a_count), MAX_A - 1);
            else chk("a_count", int'(a_count), ec_a);
         end
         held_a = int'(a_count);
         trk_a = 1'b1;
         rl_a = 0;
      end else begin
         chk("a_count_held", int'(a_count), held_a);
         if (trk_a) begin
            if (!a_ready) rl_a++;
            else begin
               chk("a_clear_cycles", rl_a, MAX_A);
               trk_a = 1'b0;
            end
         end
      end
   end

   int held_b, rl_b, ec_b, eo_b;
   bit trk_b;
   always @(negedge clk) begin
      if (!rst_n) begin
         trk_b = 1'b0;
         held_b = 0;
      end else if (b_valid) begin
         if (q_cnt_b.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_unexpected_valid: got o_valid=1 expected no pending frame");
         end else begin
            ec_b = q_cnt_b.pop_front();
            eo_b = q_ovf_b.pop_front();
            chk("b_overflow", int'(b_ovf), eo_b);
            if (eo_b != 0) chk_le("b_count_bound", int'(b_count), MAX_B - 1);
            else chk("b_count", int'(b_count), ec_b);
         end
         held_b = int'(b_count);
         trk_b = 1'b1;
         rl_b = 0;
      end else begin
         chk("b_count_held", int'(b_count), held_b);
         if (trk_b) begin
            if (!b_ready) rl_b++;
            else begin
               chk("b_clear_cycles", rl_b, MAX_B);
               trk_b = 1'b0;
            end
         end
      end
   end

   initial begin
      int dens;
      int n;
      rst_n = 1'b0;
      valid = 1'b0;
      seq = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;

      clear_frame();
      run_frame(1'b0);                                   // empty frame
      clear_frame();
      pix[0][0] = 1; pix[0][1] = 1; pix[1][0] = 1; pix[1][1] = 1;
      pix[0][5] = 1; pix[0][6] = 1; pix[1][5] = 1; pix[1][6] = 1;
      run_frame(1'b0);                                   // two squares
      clear_frame();
      for (int r = 0; r < 3; r++) begin pix[r][0] = 1; pix[r][3] = 1; end
      for (int c = 0; c < 4; c++) pix[3][c] = 1;
      run_frame(1'b0);                                   // U shape, late merge
      clear_frame();
      pix[0][0] = 1; pix[1][1] = 1; pix[2][2] = 1;
      run_frame(1'b0);                                   // diagonal
      clear_frame();
      pix[0][0] = 1; pix[0][1] = 1; pix[1][0] = 1; pix[1][1] = 1; pix[3][7] = 1;
      run_frame(1'b0);                                   // area threshold
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = ((r + c) % 2) == 0;
      run_frame(1'b0);                                   // checkerboard
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 1'(($urandom));
      run_frame(1'b1);                                   // aborted by reset
      clear_frame();
      pix[0][0] = 1; pix[0][1] = 1; pix[1][0] = 1; pix[1][1] = 1;
      pix[0][5] = 1; pix[0][6] = 1; pix[1][5] = 1; pix[1][6] = 1;
      run_frame(1'b0);

      for (int f = 0; f < 40; f++) begin
         dens = 20 * $urandom_range(1, 4);
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) pix[r][c] = ($urandom_range(0, 99) < dens);
         run_frame(1'b0);
      end

      n = 0;
      while ((q_cnt_a.size() != 0 || q_cnt_b.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("a_pending_results", q_cnt_a.size(), 0);
      chk("b_pending_results", q_cnt_b.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
